// File: rtl/ddr3_ui_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_ui_pkg
// Purpose  : Shared encodings, widths and the address-derived data pattern.
// Revision : 1.0 - initial release
// ============================================================================
package ddr3_ui_pkg;

    localparam int DEF_ADDR_WIDTH = 28;
    localparam int DEF_DATA_WIDTH = 128;
    localparam int ADDR_STEP      = 8;

    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // The address arrives zero-extended to 32 bits; pass is replicated per byte.
    function automatic logic [127:0] pattern(input logic [31:0] addr, input logic [7:0] pass);
        logic [31:0] w;
        w = addr ^ {4{pass}};
        return {w, ~w, w ^ 32'hA5A5_A5A5, w + 32'd1};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ddr3_ui_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_ui_pattern_gen
// Purpose  : Combinational test-pattern generator for one user beat.
// Revision : 1.0 - initial release
// ============================================================================
module ddr3_ui_pattern_gen
    import ddr3_ui_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [7:0]            pass,
    output logic [DATA_WIDTH-1:0] data
);

    assign data = DATA_WIDTH'(pattern(32'(addr), pass));

endmodule
`default_nettype wire

// File: rtl/ddr3_ui_traffic_checker.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_ui_traffic_checker
// Purpose  : Writes an address-derived block over the DDR3 user interface,
//            reads it back and flags data and protocol errors.
// Revision : 1.0 - initial release
// ============================================================================
module ddr3_ui_traffic_checker
    import ddr3_ui_pkg::*;
#(
    parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    NUM_BEATS  = 256,
    parameter int                    MAX_OUTST  = 16,
    parameter int                    TIMEOUT    = 4096,
    parameter bit                    LOOP       = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    init_calib_complete,
    output logic [2:0]              cmd,
    output logic                    cmd_en,
    input  logic                    cmd_ready,
    output logic [ADDR_WIDTH-1:0]   addr,
    output logic [DATA_WIDTH-1:0]   wr_data,
    output logic                    wr_data_en,
    output logic                    wr_data_end,
    output logic [DATA_WIDTH/8-1:0] wr_data_mask,
    input  logic                    wr_data_rdy,
    input  logic [DATA_WIDTH-1:0]   rd_data,
    input  logic                    rd_data_valid,
    input  logic                    rd_data_end,
    output logic                    error,
    output logic                    error1,
    output logic [15:0]             err_cnt,
    output logic [15:0]             pass_cnt,
    output logic                    busy
);

    localparam int c_cnt_w = $clog2(NUM_BEATS + 1);
    localparam int c_out_w = $clog2(MAX_OUTST + 1);
    localparam int c_tmr_w = $clog2(TIMEOUT + 1);

    localparam logic [c_cnt_w-1:0]    c_num_beats = c_cnt_w'(NUM_BEATS);
    localparam logic [c_cnt_w-1:0]    c_last_beat = c_cnt_w'(NUM_BEATS - 1);
    localparam logic [c_out_w-1:0]    c_max_outst = c_out_w'(MAX_OUTST);
    localparam logic [c_tmr_w-1:0]    c_tmo_last  = c_tmr_w'(TIMEOUT - 1);
    localparam logic [ADDR_WIDTH-1:0] c_step      = ADDR_WIDTH'(ADDR_STEP);

    state_t                r_state, w_next_state;
    logic [ADDR_WIDTH-1:0] r_wa, r_ra, r_ea;
    logic [c_cnt_w-1:0]    r_beat, r_issued, r_returned;
    logic [c_out_w-1:0]    r_outst;
    logic [c_tmr_w-1:0]    r_timer;
    logic [7:0]            r_pass;
    logic                  r_cmd_done, r_wd_done;
    logic [DATA_WIDTH-1:0] w_wr_pat, w_exp_pat;
    logic                  w_in_wr, w_in_rd, w_wr_cmd_ok, w_wr_dat_ok, w_wr_beat_done;
    logic                  w_can_issue, w_rd_cmd_hs, w_rd_beat, w_stray, w_timeout;
    logic                  w_calib_lost, w_mismatch, w_unused_rd_end;

    ddr3_ui_pattern_gen #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_wr_pat (
        .addr (r_wa),
        .pass (r_pass),
        .data (w_wr_pat)
    );

    ddr3_ui_pattern_gen #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_exp_pat (
        .addr (r_ea),
        .pass (r_pass),
        .data (w_exp_pat)
    );

    // Handshakes are derived from registered state so they never loop through cmd_en.
    assign w_in_wr        = (r_state == ST_WR);
    assign w_in_rd        = (r_state == ST_RD);
    assign w_wr_cmd_ok    = r_cmd_done | cmd_ready;
    assign w_wr_dat_ok    = r_wd_done | wr_data_rdy;
    assign w_wr_beat_done = w_in_wr & w_wr_cmd_ok & w_wr_dat_ok;
    assign w_can_issue    = w_in_rd & (r_issued != c_num_beats) & (r_outst != c_max_outst);
    assign w_rd_cmd_hs    = w_can_issue & cmd_ready;
    assign w_rd_beat      = rd_data_valid & (r_outst != '0);
    assign w_stray        = rd_data_valid & (r_outst == '0);
    assign w_timeout      = (r_outst != '0) & ~rd_data_valid & (r_timer == c_tmo_last);
    assign w_calib_lost   = (r_state != ST_IDLE) & ~init_calib_complete;
    assign w_mismatch     = w_rd_beat & (rd_data != w_exp_pat);

    assign wr_data_end     = wr_data_en;
    assign wr_data_mask    = '0;
    assign w_unused_rd_end = rd_data_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        cmd          = CMD_WR;
        cmd_en       = 1'b0;
        addr         = '0;
        wr_data_en   = 1'b0;
        wr_data      = '0;
        busy         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (init_calib_complete && start) w_next_state = ST_WR;
            end
            ST_WR: begin
                busy       = 1'b1;
                cmd_en     = ~r_cmd_done;
                wr_data_en = ~r_wd_done;
                addr       = r_wa;
                wr_data    = w_wr_pat;
                if (w_wr_beat_done && r_beat == c_last_beat) w_next_state = ST_RD;
            end
            ST_RD: begin
                busy   = 1'b1;
                cmd    = CMD_RD;
                cmd_en = w_can_issue;
                addr   = r_ra;
                if ((w_rd_beat && r_returned == c_last_beat) || w_timeout) w_next_state = ST_DONE;
            end
            default: begin
                if (LOOP && start)  w_next_state = ST_WR;
                else if (!start)    w_next_state = ST_IDLE;
            end
        endcase
        if (w_calib_lost) w_next_state = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wa       <= '0;
            r_ra       <= '0;
            r_ea       <= '0;
            r_beat     <= '0;
            r_issued   <= '0;
            r_returned <= '0;
            r_outst    <= '0;
            r_timer    <= '0;
            r_pass     <= '0;
            r_cmd_done <= 1'b0;
            r_wd_done  <= 1'b0;
            error      <= 1'b0;
            error1     <= 1'b0;
            err_cnt    <= '0;
            pass_cnt   <= '0;
        end else begin
            // pass_cnt already holds the post-increment value when leaving DONE
            if (r_state != ST_WR && w_next_state == ST_WR) begin
                r_wa   <= BASE_ADDR;
                r_beat <= '0;
                r_pass <= pass_cnt[7:0];
            end
            if (w_in_wr) begin
                if (w_wr_beat_done) begin
                    r_wa       <= r_wa + c_step;
                    r_beat     <= r_beat + 1'b1;
                    r_cmd_done <= 1'b0;
                    r_wd_done  <= 1'b0;
                end else begin
                    r_cmd_done <= w_wr_cmd_ok;
                    r_wd_done  <= w_wr_dat_ok;
                end
                if (w_wr_beat_done && r_beat == c_last_beat) begin
                    r_ra       <= BASE_ADDR;
                    r_ea       <= BASE_ADDR;
                    r_issued   <= '0;
                    r_returned <= '0;
                end
            end
            if (w_rd_cmd_hs) begin
                r_ra     <= r_ra + c_step;
                r_issued <= r_issued + 1'b1;
            end
            if (w_rd_beat) begin
                r_ea       <= r_ea + c_step;
                r_returned <= r_returned + 1'b1;
            end
            case ({w_rd_cmd_hs, w_rd_beat})
                2'b10:   r_outst <= r_outst + 1'b1;
                2'b01:   r_outst <= r_outst - 1'b1;
                default: r_outst <= r_outst;
            endcase
            if (r_outst == '0 || rd_data_valid) r_timer <= '0;
            else                                r_timer <= r_timer + 1'b1;
            if (w_timeout) r_outst <= '0;
            if (w_calib_lost) begin
                r_outst    <= '0;
                r_timer    <= '0;
                r_cmd_done <= 1'b0;
                r_wd_done  <= 1'b0;
            end
            if (w_stray || w_timeout || w_calib_lost) error1 <= 1'b1;
            if (w_mismatch) begin
                error <= 1'b1;
                if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            end
            if (r_state != ST_DONE && w_next_state == ST_DONE && !w_timeout)
                pass_cnt <= pass_cnt + 16'd1;
        end
    end

endmodule
`default_nettype wire
